// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: latches retiring instruction, extends load data, drives RF write port
// Optional DEBUG_TRACE_EN adds the debug_wb_* trace outputs.
module wb_stage #(
  parameter int          DEST_W = 5,
  parameter logic [31:0] PC_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [31:0]       ms_pc,
  input  logic              ms_gr_we,
  input  logic [DEST_W-1:0] ms_dest,
  input  logic [31:0]       ms_result,
  input  logic [2:0]        ms_ld_op,
  input  logic [31:0]       ms_ld_word,
  input  logic              wb_hold,
  output logic              rf_we,
  output logic [DEST_W-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              ws_fwd_valid,
  output logic [DEST_W-1:0] ws_fwd_dest,
  output logic [31:0]       ws_fwd_data
`ifdef DEBUG_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LW  = 3'b101;

  logic              ws_valid;
  logic              ws_ready_go;
  logic [31:0]       pc_r;
  logic              gr_we_r;
  logic [DEST_W-1:0] dest_r;
  logic [31:0]       result_r;
  logic [2:0]        ld_op_r;
  logic [31:0]       ld_word_r;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       final_data;
  logic              dest_nz;

  assign ws_ready_go = !wb_hold;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid  <= 1'b0;
      pc_r      <= PC_RST;
      gr_we_r   <= 1'b0;
      dest_r    <= '0;
      result_r  <= 32'h0;
      ld_op_r   <= 3'b000;
      ld_word_r <= 32'h0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid) begin
        pc_r      <= ms_pc;
        gr_we_r   <= ms_gr_we;
        dest_r    <= ms_dest;
        result_r  <= ms_result;
        ld_op_r   <= ms_ld_op;
        ld_word_r <= ms_ld_word;
      end
    end
  end

  // Byte lane from the low address bits; halfword lane from result[1] only.
  always_comb begin
    ld_byte    = ld_word_r[7:0];
    ld_half    = result_r[1] ? ld_word_r[31:16] : ld_word_r[15:0];
    final_data = result_r;
    case (result_r[1:0])
      2'd0: ld_byte = ld_word_r[7:0];
      2'd1: ld_byte = ld_word_r[15:8];
      2'd2: ld_byte = ld_word_r[23:16];
      2'd3: ld_byte = ld_word_r[31:24];
      default: ld_byte = ld_word_r[7:0];
    endcase
    case (ld_op_r)
      LD_LB:   final_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  final_data = {24'h0, ld_byte};
      LD_LH:   final_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  final_data = {16'h0, ld_half};
      LD_LW:   final_data = ld_word_r;
      default: final_data = result_r;
    endcase
  end

  // Register 0 has no storage, so it never writes or forwards.
  assign dest_nz      = (dest_r != '0);
  assign rf_we        = ws_valid && gr_we_r && ws_ready_go && dest_nz;
  assign rf_waddr     = ws_valid ? dest_r : '0;
  assign rf_wdata     = ws_valid ? final_data : 32'h0;
  assign ws_fwd_valid = ws_valid && gr_we_r && dest_nz;
  assign ws_fwd_dest  = dest_r;
  assign ws_fwd_data  = final_data;

`ifdef DEBUG_TRACE_EN
  assign debug_wb_pc       = pc_r;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = 5'(rf_waddr);
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_pc;
  assign unused_pc = ^pc_r;
`endif

endmodule
